// File: rtl/branch_resolver_pkg.sv
`default_nettype none
// ============================================================================
// Module  : branch_resolver_pkg
// Brief   : Shared constants for branch resolution (widths, funct3, FSM states)
// Revision: 1.0
// ============================================================================
package branch_resolver_pkg;

    localparam int XLEN_DFLT = 32;
    localparam int CNT_W_DFLT = 32;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [0:0] BR_IDLE     = 1'b0;
    localparam logic [0:0] BR_REDIRECT = 1'b1;

endpackage
`default_nettype wire

// File: rtl/branch_cmp.sv
`default_nettype none
// ============================================================================
// Module  : branch_cmp
// Brief   : Combinational branch condition evaluator (rs1, rs2, funct3 -> taken)
// Revision: 1.0
// ============================================================================
module branch_cmp
    import branch_resolver_pkg::*;
#(
    parameter int XLEN = XLEN_DFLT
) (
    input  logic [XLEN-1:0] i_rs1,
    input  logic [XLEN-1:0] i_rs2,
    input  logic [2:0]      i_funct3,
    output logic            o_taken
);

    always_comb begin
        o_taken = 1'b0;
        case (i_funct3)
            F3_BEQ:  o_taken = (i_rs1 == i_rs2);
            F3_BNE:  o_taken = (i_rs1 != i_rs2);
            F3_BLT:  o_taken = ($signed(i_rs1) <  $signed(i_rs2));
            F3_BGE:  o_taken = ($signed(i_rs1) >= $signed(i_rs2));
            F3_BLTU: o_taken = (i_rs1 <  i_rs2);
            F3_BGEU: o_taken = (i_rs1 >= i_rs2);
            default: o_taken = 1'b0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/branch_resolver.sv
`default_nettype none
// ============================================================================
// Module  : branch_resolver
// Brief   : Execute-stage branch resolution, fetch redirect and perf counters
// Revision: 1.0
// ============================================================================
module branch_resolver
    import branch_resolver_pkg::*;
#(
    parameter int XLEN  = XLEN_DFLT,
    parameter int CNT_W = CNT_W_DFLT
) (
    input  logic             clk,
    input  logic             aresetn,
    input  logic             i_instr_valid,
    output logic             o_ready,
    input  logic             i_is_op_jal,
    input  logic             i_is_op_jalr,
    input  logic             i_is_op_branch,
    input  logic [2:0]       i_funct3,
    input  logic [XLEN-1:0]  i_rs1_data,
    input  logic [XLEN-1:0]  i_rs2_data,
    input  logic [XLEN-1:0]  i_imm,
    input  logic [XLEN-1:0]  i_pc,
    input  logic             i_pred_taken,
    output logic             o_redirect_valid,
    output logic [XLEN-1:0]  o_redirect_pc,
    input  logic             i_redirect_ready,
    output logic             o_squash,
    output logic             o_link_valid,
    output logic [XLEN-1:0]  o_link_data,
    output logic             o_misalign_exc,
    output logic [CNT_W-1:0] o_br_cnt,
    output logic [CNT_W-1:0] o_mispred_cnt
);

    logic [0:0]       state_q, state_d;
    logic [XLEN-1:0]  redirect_pc_q, redirect_pc_d;
    logic             link_valid_q, link_valid_d;
    logic [XLEN-1:0]  link_data_q, link_data_d;
    logic             misalign_q, misalign_d;
    logic [CNT_W-1:0] br_cnt_q, br_cnt_d;
    logic [CNT_W-1:0] mispred_cnt_q, mispred_cnt_d;

    logic             w_cmp_taken;
    logic             w_accept;
    logic             w_is_ctrl;
    logic             w_is_link;
    logic             w_taken;
    logic [XLEN-1:0]  w_pc_target;
    logic [XLEN-1:0]  w_jalr_target;
    logic [XLEN-1:0]  w_target;
    logic [XLEN-1:0]  w_pc_plus4;
    logic             w_resolve;
    logic             w_misalign;
    logic             w_commit;
    logic             w_mispred;

    branch_cmp #(
        .XLEN (XLEN)
    ) u_branch_cmp (
        .i_rs1    (i_rs1_data),
        .i_rs2    (i_rs2_data),
        .i_funct3 (i_funct3),
        .o_taken  (w_cmp_taken)
    );

    assign w_accept      = i_instr_valid && (state_q == BR_IDLE);
    assign w_is_ctrl     = i_is_op_jal || i_is_op_jalr || i_is_op_branch;
    assign w_is_link     = i_is_op_jal || i_is_op_jalr;
    // Unconditional jumps override the comparator when several op flags are set.
    assign w_taken       = w_is_link || (i_is_op_branch && w_cmp_taken);
    assign w_pc_target   = i_pc + i_imm;
    assign w_jalr_target = (i_rs1_data + i_imm) & ~{{(XLEN-1){1'b0}}, 1'b1};
    assign w_target      = i_is_op_jalr ? w_jalr_target : w_pc_target;
    assign w_pc_plus4    = i_pc + {{(XLEN-3){1'b0}}, 3'd4};

    assign w_resolve  = w_accept && w_is_ctrl;
    assign w_misalign = w_resolve && w_taken && (w_target[1:0] != 2'b00);
    assign w_commit   = w_resolve && !w_misalign;
    assign w_mispred  = w_commit && (w_taken != i_pred_taken);

    always_comb begin
        state_d       = state_q;
        redirect_pc_d = redirect_pc_q;
        case (state_q)
            BR_IDLE: begin
                if (w_mispred) begin
                    state_d       = BR_REDIRECT;
                    redirect_pc_d = w_taken ? w_target : w_pc_plus4;
                end
            end
            BR_REDIRECT: begin
                if (i_redirect_ready) begin
                    state_d = BR_IDLE;
                end
            end
            default: state_d = BR_IDLE;
        endcase
    end

    always_comb begin
        link_valid_d  = w_commit && w_is_link;
        link_data_d   = (w_commit && w_is_link) ? w_pc_plus4 : link_data_q;
        misalign_d    = w_misalign;
        br_cnt_d      = br_cnt_q;
        mispred_cnt_d = mispred_cnt_q;
        if (w_commit && (br_cnt_q != {CNT_W{1'b1}})) begin
            br_cnt_d = br_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
        if (w_mispred && (mispred_cnt_q != {CNT_W{1'b1}})) begin
            mispred_cnt_d = mispred_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state_q       <= BR_IDLE;
            redirect_pc_q <= '0;
            link_valid_q  <= 1'b0;
            link_data_q   <= '0;
            misalign_q    <= 1'b0;
            br_cnt_q      <= '0;
            mispred_cnt_q <= '0;
        end else begin
            state_q       <= state_d;
            redirect_pc_q <= redirect_pc_d;
            link_valid_q  <= link_valid_d;
            link_data_q   <= link_data_d;
            misalign_q    <= misalign_d;
            br_cnt_q      <= br_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end

    assign o_ready          = (state_q == BR_IDLE);
    assign o_redirect_valid = (state_q == BR_REDIRECT);
    assign o_squash         = (state_q == BR_REDIRECT);
    assign o_redirect_pc    = redirect_pc_q;
    assign o_link_valid     = link_valid_q;
    assign o_link_data      = link_data_q;
    assign o_misalign_exc   = misalign_q;
    assign o_br_cnt         = br_cnt_q;
    assign o_mispred_cnt    = mispred_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_branch_resolver.sv
`default_nettype none
// ============================================================================
// Module  : tb_branch_resolver
// Brief   : Directed + random bench for branch_resolver against a reference model
// Revision: 1.0
// ============================================================================
module tb_branch_resolver;

    logic        clk;
    logic        aresetn;
    logic        i_instr_valid;
    logic        i_is_op_jal;
    logic        i_is_op_jalr;
    logic        i_is_op_branch;
    logic [2:0]  i_funct3;
    logic [31:0] i_rs1_data;
    logic [31:0] i_rs2_data;
    logic [31:0] i_imm;
    logic [31:0] i_pc;
    logic        i_pred_taken;
    logic        i_redirect_ready;

    logic        o_ready, o_redirect_valid, o_squash, o_link_valid, o_misalign_exc;
    logic [31:0] o_redirect_pc, o_link_data, o_br_cnt, o_mispred_cnt;

    logic        o4_ready, o4_redirect_valid, o4_squash, o4_link_valid, o4_misalign_exc;
    logic [31:0] o4_redirect_pc, o4_link_data;
    logic [3:0]  o4_br_cnt, o4_mispred_cnt;

    int vectors = 0;
    int miscompares = 0;

    // reference model state
    bit          m_red;
    logic [31:0] m_rpc;
    bit          m_link_v;
    logic [31:0] m_link_d;
    bit          m_exc;
    longint      m_br, m_mp, m_br4, m_mp4;

    branch_resolver #(.XLEN(32), .CNT_W(32)) dut (
        .clk(clk), .aresetn(aresetn), .i_instr_valid(i_instr_valid), .o_ready(o_ready),
        .i_is_op_jal(i_is_op_jal), .i_is_op_jalr(i_is_op_jalr), .i_is_op_branch(i_is_op_branch),
        .i_funct3(i_funct3), .i_rs1_data(i_rs1_data), .i_rs2_data(i_rs2_data), .i_imm(i_imm),
        .i_pc(i_pc), .i_pred_taken(i_pred_taken), .o_redirect_valid(o_redirect_valid),
        .o_redirect_pc(o_redirect_pc), .i_redirect_ready(i_redirect_ready), .o_squash(o_squash),
        .o_link_valid(o_link_valid), .o_link_data(o_link_data), .o_misalign_exc(o_misalign_exc),
        .o_br_cnt(o_br_cnt), .o_mispred_cnt(o_mispred_cnt)
    );

    branch_resolver #(.XLEN(32), .CNT_W(4)) dut4 (
        .clk(clk), .aresetn(aresetn), .i_instr_valid(i_instr_valid), .o_ready(o4_ready),
        .i_is_op_jal(i_is_op_jal), .i_is_op_jalr(i_is_op_jalr), .i_is_op_branch(i_is_op_branch),
        .i_funct3(i_funct3), .i_rs1_data(i_rs1_data), .i_rs2_data(i_rs2_data), .i_imm(i_imm),
        .i_pc(i_pc), .i_pred_taken(i_pred_taken), .o_redirect_valid(o4_redirect_valid),
        .o_redirect_pc(o4_redirect_pc), .i_redirect_ready(i_redirect_ready), .o_squash(o4_squash),
        .o_link_valid(o4_link_valid), .o_link_data(o4_link_data), .o_misalign_exc(o4_misalign_exc),
        .o_br_cnt(o4_br_cnt), .o_mispred_cnt(o4_mispred_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("ready", {63'd0, o_ready}, {63'd0, !m_red});
        chk("redirect_valid", {63'd0, o_redirect_valid}, {63'd0, m_red});
        chk("squash", {63'd0, o_squash}, {63'd0, m_red});
        if (m_red) chk("redirect_pc", {32'd0, o_redirect_pc}, {32'd0, m_rpc});
        chk("link_valid", {63'd0, o_link_valid}, {63'd0, m_link_v});
        if (m_link_v) chk("link_data", {32'd0, o_link_data}, {32'd0, m_link_d});
        chk("misalign_exc", {63'd0, o_misalign_exc}, {63'd0, m_exc});
        chk("br_cnt", {32'd0, o_br_cnt}, m_br);
        chk("mispred_cnt", {32'd0, o_mispred_cnt}, m_mp);
        chk("br_cnt4", {60'd0, o4_br_cnt}, m_br4);
        chk("mispred_cnt4", {60'd0, o4_mispred_cnt}, m_mp4);
        chk("redirect_valid4", {63'd0, o4_redirect_valid}, {63'd0, m_red});
    endtask

    function automatic bit cond_taken(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        int signed sa = a;
        int signed sb = b;
        case (f3)
            3'd0: return a == b;
            3'd1: return a != b;
            3'd4: return sa < sb;
            3'd5: return sa >= sb;
            3'd6: return a < b;
            3'd7: return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    // Advance the model by one clock for the inputs currently applied.
    task automatic model_step();
        bit          taken;
        logic [31:0] tgt;
        m_link_v = 1'b0;
        m_exc    = 1'b0;
        if (m_red) begin
            if (i_redirect_ready) m_red = 1'b0;
        end else if (i_instr_valid && (i_is_op_jal || i_is_op_jalr || i_is_op_branch)) begin
            if (i_is_op_jalr) begin
                taken = 1'b1;
                tgt = (i_rs1_data + i_imm) & 32'hFFFF_FFFE;
            end else if (i_is_op_jal) begin
                taken = 1'b1;
                tgt = i_pc + i_imm;
            end else begin
                taken = cond_taken(i_funct3, i_rs1_data, i_rs2_data);
                tgt = i_pc + i_imm;
            end
            if (taken && (tgt % 4 != 0)) begin
                m_exc = 1'b1;
            end else begin
                m_br  = (m_br  == 64'hFFFF_FFFF) ? m_br : m_br + 1;
                m_br4 = (m_br4 == 15) ? m_br4 : m_br4 + 1;
                if (i_is_op_jal || i_is_op_jalr) begin
                    m_link_v = 1'b1;
                    m_link_d = i_pc + 4;
                end
                if (taken != i_pred_taken) begin
                    m_red = 1'b1;
                    m_rpc = taken ? tgt : i_pc + 4;
                    m_mp  = (m_mp  == 64'hFFFF_FFFF) ? m_mp : m_mp + 1;
                    m_mp4 = (m_mp4 == 15) ? m_mp4 : m_mp4 + 1;
                end
            end
        end
    endtask

    task automatic tick(input logic v, input logic jal, input logic jalr, input logic br,
                        input logic [2:0] f3, input logic [31:0] rs1, input logic [31:0] rs2,
                        input logic [31:0] imm, input logic [31:0] pc, input logic pred,
                        input logic rr);
        @(negedge clk);
        check_all();
        i_instr_valid = v; i_is_op_jal = jal; i_is_op_jalr = jalr; i_is_op_branch = br;
        i_funct3 = f3; i_rs1_data = rs1; i_rs2_data = rs2; i_imm = imm; i_pc = pc;
        i_pred_taken = pred; i_redirect_ready = rr;
        model_step();
    endtask

    task automatic idle(input logic rr);
        tick(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, rr);
    endtask

    task automatic do_reset();
        @(negedge clk);
        aresetn = 1'b0;
        i_instr_valid = 1'b0; i_is_op_jal = 1'b0; i_is_op_jalr = 1'b0; i_is_op_branch = 1'b0;
        i_funct3 = 3'd0; i_rs1_data = '0; i_rs2_data = '0; i_imm = '0; i_pc = '0;
        i_pred_taken = 1'b0; i_redirect_ready = 1'b0;
        #1;
        m_red = 0; m_rpc = 0; m_link_v = 0; m_link_d = 0; m_exc = 0;
        m_br = 0; m_mp = 0; m_br4 = 0; m_mp4 = 0;
        check_all();
        chk("rst_redirect_pc", {32'd0, o_redirect_pc}, 64'd0);
        chk("rst_link_data", {32'd0, o_link_data}, 64'd0);
        @(negedge clk);
        aresetn = 1'b1;
    endtask

    initial begin
        aresetn = 1'b0;
        do_reset();

        // BEQ taken, predicted taken: no redirect
        tick(1, 0, 0, 1, 3'b000, 32'd5, 32'd5, 32'hFFFF_FFF0, 32'h100, 1, 0);
        idle(0);
        chk("tp_beq_br_cnt", {32'd0, o_br_cnt}, 64'd1);
        chk("tp_beq_no_redirect", {63'd0, o_redirect_valid}, 64'd0);

        // BLT taken, predicted not taken: redirect held until ready
        tick(1, 0, 0, 1, 3'b100, 32'hFFFF_FFFF, 32'd1, 32'h40, 32'h200, 0, 0);
        idle(0);
        chk("tp_blt_rpc", {32'd0, o_redirect_pc}, 64'h240);
        chk("tp_blt_squash", {63'd0, o_squash}, 64'd1);
        idle(0);
        idle(0);
        tick(1, 0, 0, 1, 3'b000, 32'd1, 32'd1, 32'h8, 32'h500, 0, 1);
        idle(0);
        chk("tp_blt_back_idle", {63'd0, o_redirect_valid}, 64'd0);
        chk("tp_blt_mispred_cnt", {32'd0, o_mispred_cnt}, 64'd1);

        // BLTU not taken with same operands, predicted taken
        tick(1, 0, 0, 1, 3'b110, 32'hFFFF_FFFF, 32'd1, 32'h40, 32'h200, 1, 0);
        idle(1);
        chk("tp_bltu_rpc", {32'd0, o_redirect_pc}, 64'h204);
        idle(0);

        // JALR always redirects, clears bit 0
        tick(1, 0, 1, 0, 3'b000, 32'h1001, 32'd0, 32'h10, 32'h300, 0, 0);
        idle(1);
        chk("tp_jalr_rpc", {32'd0, o_redirect_pc}, 64'h1010);
        chk("tp_jalr_link", {32'd0, o_link_data}, 64'h304);
        chk("tp_jalr_link_v", {63'd0, o_link_valid}, 64'd1);
        idle(0);

        // JAL to misaligned target
        tick(1, 1, 0, 0, 3'b000, 32'd0, 32'd0, 32'h6, 32'h400, 1, 0);
        idle(0);
        chk("tp_jal_exc", {63'd0, o_misalign_exc}, 64'd1);
        chk("tp_jal_no_redirect", {63'd0, o_redirect_valid}, 64'd0);
        idle(0);

        // Reset in the middle of a redirect
        tick(1, 0, 0, 1, 3'b001, 32'd1, 32'd2, 32'h20, 32'h600, 0, 0);
        idle(0);
        do_reset();

        // Saturation of the 4-bit counter instance
        for (int i = 0; i < 17; i++) tick(1, 0, 0, 1, 3'b000, i, i, 32'h8, 32'h700 + 4 * i, 1, 0);
        idle(0);
        chk("tp_sat_br_cnt4", {60'd0, o4_br_cnt}, 64'd15);
        chk("tp_sat_br_cnt", {32'd0, o_br_cnt}, 64'd17);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            logic [2:0]  ops;
            logic [31:0] a, b, imm;
            ops = 3'($urandom_range(0, 7));
            a   = $urandom;
            b   = ($urandom_range(0, 3) == 0) ? a : $urandom;
            if ($urandom_range(0, 1) == 1) begin
                a = $urandom_range(0, 16);
                b = $urandom_range(0, 16);
            end
            imm = ($urandom_range(0, 5) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
            tick(1'($urandom_range(0, 3) != 0), ops[0], ops[1], ops[2], 3'($urandom_range(0, 7)),
                 a, b, imm, $urandom & 32'hFFFF_FFFC, 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)));
            if (n == 1500) do_reset();
        end
        idle(0);
        @(negedge clk);
        check_all();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
